scan_sequencer: RTL and testbench

Upstream driver for the 4-to-16 line decoder. It steps a 4-bit select index through the 16 channels in ascending order and asserts an enable for a programmable dwell time on each channel. Masked channels are skipped, and a blanking gap is inserted between channels. Typical uses are multiplexed display, LED or keypad column scanning, with sel/en wired straight to the decoder's in/enable.

---
 rtl/scan_sequencer_if.sv | 36 +++
 rtl/scan_sequencer.sv | 169 ++++++++++++++++
 tb/tb_scan_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_if.sv
// Handshake/bus bundle between a scan controller and the scan_sequencer.
// The master drives start/stop/mask/dwell; the sequencer (slave) drives sel/en/busy/frame_done.
interface scan_sequencer_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic [15:0]        mask;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         sel;
    logic               en;
    logic               busy;
    logic               frame_done;

    modport master (
        output start,
        output stop,
        output mask,
        output dwell,
        input  sel,
        input  en,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  start,
        input  stop,
        input  mask,
        input  dwell,
        output sel,
        output en,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving a 4-to-16 decoder: blank gap, then a dwell-long enable window per unmasked channel.
// Optional macro SCAN_ONESHOT_EN: stop after one frame instead of free-running.
module scan_sequencer #(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    scan_sequencer_if.slave  bus
);

    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD =
        BLANK_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ACTIVE
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;

    logic                 mask_any;
    logic [3:0]           lowest_idx;
    logic                 next_found;
    logic [3:0]           next_idx;
    logic [DWELL_W-1:0]   dwell_load;
    logic                 enter_window;

    assign mask_any   = |bus.mask;
    // A zero dwell still yields a one-cycle window, so the down-counter loads max(dwell,1)-1.
    assign dwell_load = (bus.dwell == '0) ? '0 : (bus.dwell - DWELL_W'(1));

    // Downward iteration lets the lowest qualifying bit win.
    always_comb begin
        lowest_idx = '0;
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (bus.mask[i]) begin
                lowest_idx = 4'(i);
                if (4'(i) > sel_q) begin
                    next_found = 1'b1;
                    next_idx   = 4'(i);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = en_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        dwell_cnt_d  = dwell_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        enter_window = 1'b0;

        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (bus.start && mask_any) begin
                    sel_d        = lowest_idx;
                    busy_d       = 1'b1;
                    enter_window = 1'b1;
                end
            end

            BLANK: begin
                en_d = 1'b0;
                if (blank_cnt_q == '0) begin
                    state_d     = ACTIVE;
                    en_d        = 1'b1;
                    dwell_cnt_d = dwell_load;
                end else begin
                    blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                end
            end

            ACTIVE: begin
                if (dwell_cnt_q == '0) begin
                    en_d = 1'b0;
                    if (!mask_any) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else if (next_found) begin
                        sel_d        = next_idx;
                        enter_window = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
`ifdef SCAN_ONESHOT_EN
                        state_d = IDLE;
                        busy_d  = 1'b0;
`else
                        sel_d        = lowest_idx;
                        enter_window = 1'b1;
`endif
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // With no blanking gap the new channel's window opens immediately.
        if (enter_window) begin
            if (BLANK_CYCLES == 0) begin
                state_d     = ACTIVE;
                en_d        = 1'b1;
                dwell_cnt_d = dwell_load;
            end else begin
                state_d     = BLANK;
                en_d        = 1'b0;
                blank_cnt_d = BLANK_LOAD;
            end
        end

        if (bus.stop) begin
            state_d      = IDLE;
            sel_d        = sel_q;
            en_d         = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = 1'b0;
            dwell_cnt_d  = '0;
            blank_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            dwell_cnt_q  <= '0;
            blank_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            dwell_cnt_q  <= dwell_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: channel-schedule model checked every cycle plus hand-computed literal checks.
// Honours SCAN_ONESHOT_EN when defined.
module tb_scan_sequencer;

    localparam int DWELL_W = 16;
    localparam int BLANK   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    scan_sequencer #(
        .DWELL_W      (DWELL_W),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int rel    = 0;
    bit model_on = 1'b0;

    // Model: a channel period is BLANK gap cycles followed by max(dwell,1) enable cycles.
    bit m_run;
    int m_sel;
    bit m_fd;
    int m_pos;
    int m_d;
    int m_nxt;

    function automatic int lowestSet(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic int effDwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    task automatic beginChannel();
        m_pos = 0;
        m_d   = (BLANK == 0) ? effDwell(bus.dwell) : 1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_sel = 0; m_fd = 1'b0; m_pos = 0; m_d = 1;
            model_on = 1'b1;
        end else if (bus.stop) begin
            m_run = 1'b0; m_fd = 1'b0;
        end else if (!m_run) begin
            m_fd = 1'b0;
            if (bus.start && bus.mask != 16'h0) begin
                m_run = 1'b1;
                m_sel = lowestSet(bus.mask);
                beginChannel();
            end
        end else begin
            m_fd = 1'b0;
            if (BLANK > 0 && m_pos == BLANK - 1) m_d = effDwell(bus.dwell);
            if (m_pos == BLANK + m_d - 1) begin
                if (bus.mask == 16'h0) begin
                    m_run = 1'b0;
                end else begin
                    m_nxt = -1;
                    for (int i = 1; i <= 16; i++) begin
                        if (m_nxt < 0 && bus.mask[(m_sel + i) % 16]) m_nxt = (m_sel + i) % 16;
                    end
                    if (m_nxt <= m_sel) begin
                        m_fd = 1'b1;
`ifdef SCAN_ONESHOT_EN
                        m_run = 1'b0;
`else
                        m_sel = m_nxt;
                        beginChannel();
`endif
                    end else begin
                        m_sel = m_nxt;
                        beginChannel();
                    end
                end
            end else begin
                m_pos++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at rel %0d: got %0h, expected %0h", name, rel, act, exp);
        end
    endtask

    // Packed {sel,en,busy,frame_done} compared against the model every cycle.
    always @(posedge clk) begin
        logic m_en;
        #1;
        if (model_on) begin
            m_en = m_run && (m_pos >= BLANK);
            checkOutput("cycle", {25'h0, bus.sel, bus.en, bus.busy, bus.frame_done},
                        {25'h0, 4'(m_sel), m_en, m_run, m_fd});
        end
    end

    task automatic applyStimulus(input logic st, input logic sp,
                                 input logic [15:0] m, input logic [DWELL_W-1:0] d);
        bus.start = st;
        bus.stop  = sp;
        bus.mask  = m;
        bus.dwell = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic waitRel(input int n);
        while (rel < n) tick();
    endtask

    task automatic startScan(input logic [15:0] m, input logic [DWELL_W-1:0] d);
        applyStimulus(1'b1, 1'b0, m, d);
        rel = 0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic stopScan();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, '0);
        tick();
        tick();
        checkOutput("rst_sel", 32'(bus.sel), 32'd0);
        checkOutput("rst_en", 32'(bus.en), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_fd", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        tick();

`ifdef SCAN_ONESHOT_EN
        startScan(16'h0003, 16'd2);
        waitRel(1);  checkOutput("os_busy1", 32'(bus.busy), 32'd1);
        waitRel(3);  checkOutput("os_en0", 32'(bus.en), 32'd1);
        waitRel(7);  checkOutput("os_sel1", 32'(bus.sel), 32'd1);
                     checkOutput("os_en1", 32'(bus.en), 32'd1);
        waitRel(9);  checkOutput("os_fd", 32'(bus.frame_done), 32'd1);
                     checkOutput("os_idle", 32'(bus.busy), 32'd0);
        waitRel(12); checkOutput("os_stay", 32'(bus.busy), 32'd0);
        startScan(16'h0003, 16'd2);
        waitRel(3);  checkOutput("os2_en0", 32'(bus.en), 32'd1);
        waitRel(9);  checkOutput("os2_fd", 32'(bus.frame_done), 32'd1);
        waitRel(12);
`else
        startScan(16'hFFFF, 16'd3);
        waitRel(1);   checkOutput("t1_busy", 32'(bus.busy), 32'd1);
                      checkOutput("t1_en_blank", 32'(bus.en), 32'd0);
        waitRel(3);   checkOutput("t1_en_rise", 32'(bus.en), 32'd1);
        waitRel(5);   checkOutput("t1_en_last", 32'(bus.en), 32'd1);
        waitRel(6);   checkOutput("t1_sel1", 32'(bus.sel), 32'd1);
                      checkOutput("t1_en_fall", 32'(bus.en), 32'd0);
        waitRel(80);  checkOutput("t1_no_fd", 32'(bus.frame_done), 32'd0);
        waitRel(81);  checkOutput("t1_fd1", 32'(bus.frame_done), 32'd1);
                      checkOutput("t1_wrap", 32'(bus.sel), 32'd0);
        waitRel(100); bus.start = 1'b1;
        tick();       bus.start = 1'b0;
        waitRel(161); checkOutput("t1_fd2", 32'(bus.frame_done), 32'd1);
        waitRel(164); bus.stop = 1'b1;
        tick();       bus.stop = 1'b0;
        checkOutput("t4_stop_en", 32'(bus.en), 32'd0);
        checkOutput("t4_stop_busy", 32'(bus.busy), 32'd0);
        tick();

        applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'd3);
        checkOutput("t4_ss_busy", 32'(bus.busy), 32'd0);
        tick();
        checkOutput("t4_ss_busy2", 32'(bus.busy), 32'd0);

        startScan(16'h8421, 16'd1);
        waitRel(3);  checkOutput("t2_en0", 32'(bus.en), 32'd1);
        waitRel(4);  checkOutput("t2_sel5", 32'(bus.sel), 32'd5);
        waitRel(10); checkOutput("t2_sel15", 32'(bus.sel), 32'd15);
        waitRel(13); checkOutput("t2_fd", 32'(bus.frame_done), 32'd1);
                     checkOutput("t2_wrap", 32'(bus.sel), 32'd0);
        waitRel(30);
        stopScan();

        startScan(16'h0010, 16'd0);
        waitRel(1);  checkOutput("t3_sel4", 32'(bus.sel), 32'd4);
        waitRel(3);  checkOutput("t3_en", 32'(bus.en), 32'd1);
        waitRel(4);  checkOutput("t3_fd", 32'(bus.frame_done), 32'd1);
        waitRel(6);  checkOutput("t3_en2", 32'(bus.en), 32'd1);
        waitRel(7);  checkOutput("t3_fd2", 32'(bus.frame_done), 32'd1);
        waitRel(12);
        stopScan();

        startScan(16'h0005, 16'd2);
        waitRel(3);  bus.dwell = 16'd6;
        waitRel(4);  checkOutput("dw_en_last", 32'(bus.en), 32'd1);
        waitRel(5);  checkOutput("dw_sel2", 32'(bus.sel), 32'd2);
        waitRel(12); checkOutput("dw_en_long", 32'(bus.en), 32'd1);
        waitRel(13); checkOutput("dw_fd", 32'(bus.frame_done), 32'd1);
        stopScan();

        startScan(16'hFFFF, 16'd4);
        waitRel(4);  bus.mask = 16'h0;
        waitRel(6);  checkOutput("t5_finish", 32'(bus.en), 32'd1);
        waitRel(7);  checkOutput("t5_idle", 32'(bus.busy), 32'd0);
                     checkOutput("t5_no_fd", 32'(bus.frame_done), 32'd0);
        startScan(16'h0000, 16'd4);
        checkOutput("t5_zero_start", 32'(bus.busy), 32'd0);
        tick();

        startScan(16'hF100, 16'd2);
        waitRel(5);  checkOutput("rs_sel12", 32'(bus.sel), 32'd12);
        waitRel(8);  rst = 1'b1;
        tick();      rst = 1'b0;
        checkOutput("rs_sel0", 32'(bus.sel), 32'd0);
        checkOutput("rs_busy0", 32'(bus.busy), 32'd0);
        startScan(16'hF100, 16'd2);
        checkOutput("rs_restart", 32'(bus.sel), 32'd8);
        waitRel(10);
        stopScan();
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
